// File: rtl/pc_3gpp_rate_match.sv
// Polar rate matcher: buffers one encoded frame, applies the 32-sub-block
// interleaver and emits E bits by repetition, puncturing or shortening.
module pc_3gpp_rate_match #(
  parameter int pN_MAX = 1024,
  parameter int pE_W   = 14,
  parameter int pTAG_W = 4
) (
  input  logic              iclk,
  input  logic              ireset,
  input  logic              iclkena,
  input  logic              ifull,
  output logic              oreq,
  input  logic              isop,
  input  logic              ival,
  input  logic              ieop,
  input  logic              idat,
  input  logic [pTAG_W-1:0] itag,
  input  logic [3:0]        iN_LOG2,
  input  logic [pE_W-1:0]   iE,
  input  logic              ishort,
  input  logic              ireq,
  output logic              ofull,
  output logic              osop,
  output logic              oval,
  output logic              oeop,
  output logic              odat,
  output logic [pTAG_W-1:0] otag
);

  localparam int AW = $clog2(pN_MAX);
  localparam logic [3:0] LGMAX = 4'(AW);
  localparam logic [4:0] PTAB [32] = '{
    5'd0,  5'd1,  5'd2,  5'd4,  5'd3,  5'd5,  5'd6,  5'd7,
    5'd8,  5'd16, 5'd9,  5'd17, 5'd10, 5'd18, 5'd11, 5'd19,
    5'd12, 5'd20, 5'd13, 5'd21, 5'd14, 5'd22, 5'd15, 5'd23,
    5'd24, 5'd25, 5'd26, 5'd28, 5'd27, 5'd29, 5'd30, 5'd31
  };

  typedef enum logic [1:0] {IDLE, LOAD, READY, EMIT} state_t;

  state_t state_q, state_d;
  logic [AW:0]       wcnt_q, wcnt_d;
  logic [AW-1:0]     ptr_q, ptr_d;
  logic [pE_W-1:0]   kcnt_q, kcnt_d;
  logic [pE_W-1:0]   e_q, e_d;
  logic [3:0]        lg_q, lg_d;
  logic              short_q, short_d;
  logic [pTAG_W-1:0] tag_q, tag_d;
  logic oreq_q, oreq_d, ofull_q, ofull_d;
  logic osop_q, osop_d, oval_q, oval_d, oeop_q, oeop_d;
  logic odat_q;
  logic [pTAG_W-1:0] otag_q;

  logic mem [pN_MAX];

  logic            sop, we, re;
  logic [3:0]      lg_in, lg_w, sh;
  logic [pE_W-1:0] e_w;
  logic            short_w;
  logic [AW:0]     n_w, n_q;
  logic [AW-1:0]   waddr, raddr, mask_q, pj;
  logic [4:0]      idx;
  logic [31:0]     e32, n32;

  always_comb begin
    if (iN_LOG2 < 4'd5)      lg_in = 4'd5;
    else if (iN_LOG2 > LGMAX) lg_in = LGMAX;
    else                      lg_in = iN_LOG2;
  end

  // Frame parameters as seen this cycle, including a same-cycle isop.
  assign sop     = isop & ival;
  assign lg_w    = sop ? lg_in  : lg_q;
  assign e_w     = sop ? iE     : e_q;
  assign short_w = sop ? ishort : short_q;
  assign n_w     = (AW+1)'(1) << lg_w;
  assign n_q     = (AW+1)'(1) << lg_q;
  assign mask_q  = AW'(n_q - (AW+1)'(1));
  assign e32     = 32'(e_w);
  assign n32     = 32'(n_w);
  assign waddr   = sop ? '0 : AW'(wcnt_q);

  // Interleaver address by shift/mask: P(i) << (lg-5) | low bits.
  assign sh    = lg_q - 4'd5;
  assign idx   = 5'(ptr_q >> sh);
  assign pj    = AW'(PTAB[idx]) << sh;
  assign raddr = pj | (ptr_q & (mask_q >> 5));

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    ptr_d   = ptr_q;
    kcnt_d  = kcnt_q;
    e_d     = e_q;
    lg_d    = lg_q;
    short_d = short_q;
    tag_d   = tag_q;
    oreq_d  = 1'b0;
    ofull_d = ofull_q;
    osop_d  = 1'b0;
    oval_d  = 1'b0;
    oeop_d  = 1'b0;
    we      = 1'b0;
    re      = 1'b0;
    unique case (state_q)
      IDLE: begin
        wcnt_d = '0;
        if (ifull) begin
          oreq_d  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (sop) begin
          lg_d    = lg_in;
          e_d     = iE;
          short_d = ishort;
          tag_d   = itag;
        end
        if (ival && (sop || wcnt_q < n_w)) begin
          we     = 1'b1;
          wcnt_d = (AW+1)'(waddr) + (AW+1)'(1);
        end
        if (ival && ieop) begin
          kcnt_d = '0;
          if (!short_w && e32 < n32) ptr_d = AW'(n32 - e32);
          else                       ptr_d = '0;
          if (e_w == '0) begin
            state_d = IDLE;
          end else begin
            state_d = READY;
            ofull_d = 1'b1;
          end
        end
      end
      READY: begin
        if (ireq) begin
          state_d = EMIT;
          ofull_d = 1'b0;
        end
      end
      EMIT: begin
        re     = 1'b1;
        oval_d = 1'b1;
        osop_d = (kcnt_q == '0);
        oeop_d = (kcnt_q == e_q - pE_W'(1));
        kcnt_d = kcnt_q + pE_W'(1);
        ptr_d  = (ptr_q + AW'(1)) & mask_q;
        if (oeop_d) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (ireset) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      ptr_q   <= '0;
      kcnt_q  <= '0;
      e_q     <= '0;
      lg_q    <= 4'd5;
      short_q <= 1'b0;
      tag_q   <= '0;
      oreq_q  <= 1'b0;
      ofull_q <= 1'b0;
      osop_q  <= 1'b0;
      oval_q  <= 1'b0;
      oeop_q  <= 1'b0;
      odat_q  <= 1'b0;
      otag_q  <= '0;
    end else if (iclkena) begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      ptr_q   <= ptr_d;
      kcnt_q  <= kcnt_d;
      e_q     <= e_d;
      lg_q    <= lg_d;
      short_q <= short_d;
      tag_q   <= tag_d;
      oreq_q  <= oreq_d;
      ofull_q <= ofull_d;
      osop_q  <= osop_d;
      oval_q  <= oval_d;
      oeop_q  <= oeop_d;
      odat_q  <= re ? mem[raddr] : 1'b0;
      if (re) otag_q <= tag_q;
    end
  end

  always_ff @(posedge iclk) begin
    if (iclkena && we) mem[waddr] <= idat;
  end

  // Strobes are masked so each output bit shows on exactly one enabled cycle.
  assign oreq  = oreq_q;
  assign ofull = ofull_q;
  assign osop  = osop_q & iclkena;
  assign oval  = oval_q & iclkena;
  assign oeop  = oeop_q & iclkena;
  assign odat  = odat_q;
  assign otag  = otag_q;

endmodule
